// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the multiply/divide issue controller:
// mode codes, FSM states and start-op classification helpers.
package md_issue_ctrl_pkg;

    localparam logic [3:0] MULDIVMode_NONE  = 4'd0;
    localparam logic [3:0] MULDIVMode_MULT  = 4'd1;
    localparam logic [3:0] MULDIVMode_MULTU = 4'd2;
    localparam logic [3:0] MULDIVMode_DIV   = 4'd3;
    localparam logic [3:0] MULDIVMode_DIVU  = 4'd4;
    localparam logic [3:0] MULDIVMode_MTHI  = 4'd5;
    localparam logic [3:0] MULDIVMode_MTLO  = 4'd6;
    localparam logic [3:0] MULDIVMode_MFHI  = 4'd7;
    localparam logic [3:0] MULDIVMode_MFLO  = 4'd8;

    typedef enum logic [1:0] {
        MD_IDLE     = 2'd0,
        MD_MUL_BUSY = 2'd1,
        MD_DIV_BUSY = 2'd2
    } md_state_e;

    function automatic logic is_mul_op(input logic [3:0] m);
        return (m == MULDIVMode_MULT) || (m == MULDIVMode_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] m);
        return (m == MULDIVMode_DIV) || (m == MULDIVMode_DIVU);
    endfunction

    // Ops that hand work to the unit (mfhi/mflo only read results)
    function automatic logic is_md_start_op(input logic [3:0] m);
        return is_mul_op(m) || is_div_op(m) ||
               (m == MULDIVMode_MTHI) || (m == MULDIVMode_MTLO);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Loadable down-counter shadowing the muldiv unit's busy window.
// Flags the final busy cycle so the FSM can return to idle.
module md_busy_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    // Load on issue, otherwise count down and hold at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue controller for the muldiv start/busy handshake: issues
// start strobes, shadows the busy window and stalls HI/LO users in D.
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_valid,
    input  logic [3:0]       e_mode,
    input  logic             e_flush,
    input  logic             d_uses_md,
    output logic             md_start,
    output logic [3:0]       md_mode,
    output logic             md_busy,
    output logic             md_stall,
    output logic [CNT_W-1:0] cnt_dbg
);

    md_state_e        state_q;
    md_state_e        state_d;
    logic             e_start_op;
    logic             issue;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             last;

    assign e_start_op = e_valid & ~e_flush & is_md_start_op(e_mode);
    assign issue      = e_start_op & (state_q == MD_IDLE);

    md_busy_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .load_val(load_val),
        .cnt     (cnt_dbg),
        .last    (last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and counter load; busy states ignore start ops
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        unique case (state_q)
            MD_IDLE: begin
                if (issue && is_mul_op(e_mode)) begin
                    state_d  = MD_MUL_BUSY;
                    load     = 1'b1;
                    load_val = CNT_W'(MULT_CYCLES);
                end else if (issue && is_div_op(e_mode)) begin
                    state_d  = MD_DIV_BUSY;
                    load     = 1'b1;
                    load_val = CNT_W'(DIV_CYCLES);
                end
            end
            MD_MUL_BUSY, MD_DIV_BUSY: begin
                if (last) begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Handshake outputs and D-stage stall
    always_comb begin
        md_start = issue;
        md_mode  = issue ? e_mode : MULDIVMode_NONE;
        md_busy  = (state_q != MD_IDLE);
        md_stall = d_uses_md & ((state_q != MD_IDLE) | e_start_op);
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl: expected outputs are queued
// when stimulus is driven and compared on the following negedge.
module tb_md_issue_ctrl;
    import md_issue_ctrl_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       e_valid = 1'b0;
    logic [3:0] e_mode = MULDIVMode_NONE;
    logic       e_flush = 1'b0;
    logic       d_uses_md = 1'b0;
    logic       md_start;
    logic [3:0] md_mode;
    logic       md_busy;
    logic       md_stall;
    logic [3:0] cnt_dbg;

    typedef struct {
        logic       start;
        logic [3:0] mode;
        logic       busy;
        logic       stall;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   left    = 0;
    int   exp_starts = 0;
    int   seen_starts = 0;

    md_issue_ctrl #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC),
        .CNT_W      (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .e_valid  (e_valid),
        .e_mode   (e_mode),
        .e_flush  (e_flush),
        .d_uses_md(d_uses_md),
        .md_start (md_start),
        .md_mode  (md_mode),
        .md_busy  (md_busy),
        .md_stall (md_stall),
        .cnt_dbg  (cnt_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // One cycle of stimulus; expectation comes from an integer
    // countdown of remaining busy cycles.
    task automatic step(input logic v, input logic [3:0] m,
                        input logic f, input logic d, input logic r);
        exp_t e;
        logic sop;
        logic iss;
        @(posedge clk);
        #1;
        e_valid   = v;
        e_mode    = m;
        e_flush   = f;
        d_uses_md = d;
        reset     = r;
        sop = v && !f && (m inside {MULDIVMode_MULT, MULDIVMode_MULTU,
                                    MULDIVMode_DIV, MULDIVMode_DIVU,
                                    MULDIVMode_MTHI, MULDIVMode_MTLO});
        iss = sop && (left == 0);
        e.start = iss;
        e.mode  = iss ? m : MULDIVMode_NONE;
        e.busy  = (left > 0);
        e.stall = d && ((left > 0) || sop);
        e.cnt   = 4'(left);
        sb.push_back(e);
        if (iss) exp_starts++;
        if (r) left = 0;
        else if (iss && (m == MULDIVMode_MULT || m == MULDIVMode_MULTU)) left = MC;
        else if (iss && (m == MULDIVMode_DIV || m == MULDIVMode_DIVU)) left = DC;
        else if (left > 0) left--;
    endtask

    task automatic idle(input int n, input logic d);
        for (int i = 0; i < n; i++) step(1'b0, MULDIVMode_NONE, 1'b0, d, 1'b0);
    endtask

    // Monitor: compare DUT outputs against queued expectations
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (md_start === 1'b1) seen_starts++;
            chk("md_start", int'(md_start), int'(e.start));
            chk("md_mode",  int'(md_mode),  int'(e.mode));
            chk("md_busy",  int'(md_busy),  int'(e.busy));
            chk("md_stall", int'(md_stall), int'(e.stall));
            chk("cnt_dbg",  int'(cnt_dbg),  int'(e.cnt));
        end
    end

    initial begin
        // Reset
        step(1'b0, MULDIVMode_NONE, 1'b0, 1'b0, 1'b1);
        step(1'b0, MULDIVMode_NONE, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);

        // MULT: busy T1..T5, cnt 5..1 then 0
        step(1'b1, MULDIVMode_MULT, 1'b0, 1'b0, 1'b0);
        idle(7, 1'b0);

        // DIVU with mflo waiting in D: stall T0..T10
        step(1'b1, MULDIVMode_DIVU, 1'b0, 1'b1, 1'b0);
        idle(11, 1'b1);
        idle(2, 1'b0);

        // MTHI: single-cycle, no busy
        step(1'b1, MULDIVMode_MTHI, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);
        step(1'b1, MULDIVMode_MTLO, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);

        // Flushed DIV does not issue, next DIV does
        step(1'b1, MULDIVMode_DIV, 1'b1, 1'b0, 1'b0);
        step(1'b1, MULDIVMode_DIV, 1'b0, 1'b0, 1'b0);
        idle(12, 1'b0);

        // Reset mid-divide, MULTU right after
        step(1'b1, MULDIVMode_DIV, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b0, MULDIVMode_NONE, 1'b0, 1'b0, 1'b1);
        step(1'b1, MULDIVMode_MULTU, 1'b0, 1'b0, 1'b0);
        idle(6, 1'b0);

        // Bubbles with a start mode never issue
        for (int i = 0; i < 3; i++)
            step(1'b0, MULDIVMode_MULT, 1'b0, 1'b1, 1'b0);

        // Illegal start while busy is ignored; flush does not abort
        step(1'b1, MULDIVMode_MULT, 1'b0, 1'b0, 1'b0);
        step(1'b1, MULDIVMode_DIV, 1'b0, 1'b1, 1'b0);
        step(1'b1, MULDIVMode_MTLO, 1'b1, 1'b0, 1'b0);
        step(1'b1, MULDIVMode_MFHI, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b0);
        step(1'b1, MULDIVMode_MFLO, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);

        @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        chk("start_count", seen_starts, exp_starts);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
